sync_fifo_param: RTL



---
 rtl/sync_fifo_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, occupancy count, synchronous flush and optional FWFT read mode.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter bit FWFT       = 1'b0,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (DEPTH < 2 || AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH - 1) begin : g_bad_params
        $error("sync_fifo_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rv_q, rv_d;
    logic                  ack_q, ack_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_acc, wr_acc;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_acc = rd_en && (count_q != '0);
    assign wr_acc = wr_en && ((count_q != DEPTH_C) || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        rv_d     = 1'b0;
        ack_d    = 1'b0;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            ack_d = wr_acc;
            ovf_d = wr_en && !wr_acc;
            udf_d = rd_en && !rd_acc;
            rv_d  = rd_acc;
            if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                data_d   = mem_q[rd_ptr_q];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            rv_q     <= 1'b0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            rv_q     <= rv_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= AF_C) && !full;
    assign almostempty = !empty && (count_q <= AE_C);
    assign count       = count_q;
    assign wr_ack      = ack_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

    // FWFT shows the head entry live; when empty it falls back to the last popped word.
    if (FWFT) begin : g_fwft
        assign data_out = empty ? data_q : mem_q[rd_ptr_q];
        assign rd_valid = !empty;
    end else begin : g_std
        assign data_out = data_q;
        assign rd_valid = rv_q;
    end

endmodule
